// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_tx-side signals for uart_tx_arbiter.
//   master : arbiter view. It reads req/req_data/req_last/tx_done and drives
//            ack/grant/tx_start/tx_data/busy/timeout_err/err_id.
//   slave  : environment view (requesters plus uart_tx), the mirror image.
// Handshake: a requester raises req[i] with req_data/req_last and holds all
// three until it samples ack[i] high. It may change them at the edge that
// ends the ack cycle. ack[i] is a one-cycle pulse that means the byte has
// fully left the transmitter. uart_tx sees a one-cycle tx_start with tx_data
// held stable until it answers with a one-cycle tx_done.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         ack;
  logic [N_REQ-1:0]         grant;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_done;
  logic                     busy;
  logic                     timeout_err;
  logic [$clog2(N_REQ)-1:0] err_id;

  modport master (
    input  req, req_data, req_last, tx_done,
    output ack, grant, tx_start, tx_data, busy, timeout_err, err_id
  );

  modport slave (
    output req, req_data, req_last, tx_done,
    input  ack, grant, tx_start, tx_data, busy, timeout_err, err_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte-stream requesters.
// Arbitration is round-robin from ptr. A byte with req_last=0 locks the
// transmitter to its owner until the packet ends. A watchdog aborts a byte
// whose tx_done never arrives.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : uart_tx_arbiter_if.master. It carries req/req_data/req_last/ack
//                to the requesters and tx_start/tx_data/tx_done to uart_tx,
//                plus the grant/busy/timeout_err/err_id status outputs.
//   dbg_state  : current FSM state (0 IDLE, 1 START, 2 WAIT, 3 ACK, 4 NEXT)
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 131072
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus,
  output logic [2:0]        dbg_state
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  sel, sel_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [IDX_W-1:0]  err_id_q, err_id_n;
  logic              lock, lock_n;
  logic              timeout_err_q, timeout_err_n;
  logic [N_REQ-1:0]  grant_q, grant_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              found;
  logic [IDX_W-1:0]  win;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  // Round-robin search: first set req bit scanning ptr, ptr+1, ... mod N_REQ.
  always_comb begin
    int j;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    win   = ptr;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IDX_W'(j);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n       = state;
    sel_n         = sel;
    ptr_n         = ptr;
    err_id_n      = err_id_q;
    lock_n        = lock;
    timeout_err_n = 1'b0;
    grant_n       = grant_q;
    data_n        = data_q;
    cnt_n         = cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          sel_n   = win;
          data_n  = req_bytes[win];
          lock_n  = ~bus.req_last[win];
          grant_n = N_REQ'(1) << win;
          state_n = S_START;
        end
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        // The abort fires on the cycle the counter would step to TIMEOUT-1,
        // so timeout_err lands TIMEOUT cycles after tx_start.
        if (bus.tx_done) begin
          state_n = S_ACK;
        end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
          timeout_err_n = 1'b1;
          err_id_n      = sel;
          grant_n       = '0;
          lock_n        = 1'b0;
          ptr_n         = next_idx(sel);
          state_n       = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (lock) begin
          state_n = S_NEXT;
        end else begin
          grant_n = '0;
          ptr_n   = next_idx(sel);
          state_n = S_IDLE;
        end
      end
      S_NEXT: begin
        // Owner of a locked packet has had one cycle after ack to present
        // the next byte. If req has dropped, the packet is abandoned.
        if (bus.req[sel]) begin
          data_n  = req_bytes[sel];
          lock_n  = ~bus.req_last[sel];
          state_n = S_START;
        end else begin
          lock_n  = 1'b0;
          grant_n = '0;
          ptr_n   = next_idx(sel);
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sel           <= '0;
      ptr           <= '0;
      err_id_q      <= '0;
      lock          <= 1'b0;
      timeout_err_q <= 1'b0;
      grant_q       <= '0;
      data_q        <= '0;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      sel           <= sel_n;
      ptr           <= ptr_n;
      err_id_q      <= err_id_n;
      lock          <= lock_n;
      timeout_err_q <= timeout_err_n;
      grant_q       <= grant_n;
      data_q        <= data_n;
      cnt           <= cnt_n;
    end
  end

  // Every output comes from a register or a decode of the registered state.
  assign bus.tx_start    = (state == S_START);
  assign bus.ack         = (state == S_ACK) ? (N_REQ'(1) << sel) : '0;
  assign bus.busy        = (state != S_IDLE);
  assign bus.grant       = grant_q;
  assign bus.tx_data     = data_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_id      = err_id_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, TIMEOUT=16).
// The bench plays the requesters and uart_tx. Inputs are driven and outputs
// are sampled 1 time unit after each rising edge. Expected bytes are queued
// in exp_q and popped as each tx_start is observed.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         rr_order[6] = '{0, 1, 3, 0, 1, 3};

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.tx_done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus.ack, bus.grant, bus.tx_start, bus.tx_data, bus.busy,
                bus.timeout_err, bus.err_id, dbg_state});
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]        = l;
    bus.req[i]             = 1'b1;
  endtask

  // Wait (bounded) for tx_start, check owner and byte, hold two WAIT cycles,
  // answer with tx_done and check the single-cycle ack.
  task automatic serve(input string tag, input logic [3:0] g, output int lat);
    logic [7:0] d;
    lat = 0;
    while (bus.tx_start !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    if (exp_q.size() == 0) d = 8'hxx;
    else d = exp_q.pop_front();
    chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_data"}, 32'(bus.tx_data), 32'(d));
    step();
    step();
    chk({tag, "_wait"}, 32'({bus.tx_start, bus.busy, bus.grant, bus.tx_data}),
        32'({1'b0, 1'b1, g, d}));
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk({tag, "_ack"}, 32'(bus.ack), 32'(g));
    step();
    chk({tag, "_ack_once"}, 32'(bus.ack), 32'd0);
  endtask

  initial begin
    int       lat;
    int       n;
    logic [3:0] ack_seen;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_done  = 1'b0;
    step();
    step();
    chk("reset_outputs", all_out(), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", all_out(), 32'd0);

    // single byte from requester 0
    set_req(0, 8'h55, 1'b1);
    exp_q.push_back(8'h55);
    serve("single", 4'b0001, lat);
    chk("single_latency", 32'(lat), 32'd1);
    bus.req[0] = 1'b0;
    chk("single_idle", 32'({bus.grant, bus.busy, dbg_state}), 32'd0);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("done_in_idle_ignored", 32'({bus.ack, bus.busy, dbg_state}), 32'd0);

    // round robin 0,1,3,0,1,3
    apply_reset();
    set_req(0, 8'hA0, 1'b1);
    set_req(1, 8'hA1, 1'b1);
    set_req(3, 8'hA3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'hA0 + 8'(rr_order[i]));
      serve($sformatf("rr%0d", i), 4'(1 << rr_order[i]), lat);
      chk($sformatf("rr%0d_latency", i), 32'(lat), 32'd1);
    end
    bus.req = '0;

    // packet lock: 10,11,12 from req0 then 20 from req2
    apply_reset();
    set_req(0, 8'h10, 1'b0);
    set_req(2, 8'h20, 1'b1);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h20);
    serve("pkt0", 4'b0001, lat);
    chk("pkt_next_grant", 32'({bus.grant, dbg_state}), 32'({4'b0001, 3'd4}));
    set_req(0, 8'h11, 1'b0);
    serve("pkt1", 4'b0001, lat);
    chk("pkt1_gap", 32'(lat), 32'd1);
    set_req(0, 8'h12, 1'b1);
    serve("pkt2", 4'b0001, lat);
    bus.req[0] = 1'b0;
    serve("pkt3", 4'b0100, lat);
    bus.req = '0;

    // watchdog: req1 never sees tx_done
    apply_reset();
    set_req(1, 8'h31, 1'b1);
    set_req(2, 8'h42, 1'b1);
    step();
    chk("wd_start", 32'({bus.tx_start, bus.grant}), 32'({1'b1, 4'b0010}));
    n = 0;
    ack_seen = '0;
    while (bus.timeout_err !== 1'b1 && n < 40) begin
      step();
      n++;
      ack_seen = ack_seen | bus.ack;
    end
    chk("wd_cycles", 32'(n), 32'd16);
    chk("wd_no_ack", 32'(ack_seen), 32'd0);
    chk("wd_abort", 32'({bus.err_id, bus.grant, bus.busy}), 32'({2'd1, 4'b0000, 1'b0}));
    exp_q.push_back(8'h42);
    serve("wd_r2", 4'b0100, lat);
    chk("wd_err_hold", 32'({bus.err_id, bus.timeout_err}), 32'({2'd1, 1'b0}));
    bus.req[2] = 1'b0;
    exp_q.push_back(8'h31);
    serve("wd_r1", 4'b0010, lat);
    bus.req = '0;

    // abandon: locked req0 drops req, ptr must move past 0
    apply_reset();
    set_req(0, 8'h51, 1'b0);
    set_req(1, 8'h61, 1'b1);
    exp_q.push_back(8'h51);
    serve("ab0", 4'b0001, lat);
    bus.req[0] = 1'b0;
    step();
    chk("ab_idle", 32'({bus.grant, bus.busy, dbg_state}), 32'd0);
    set_req(0, 8'h52, 1'b1);
    exp_q.push_back(8'h61);
    serve("ab1", 4'b0010, lat);
    bus.req[1] = 1'b0;
    exp_q.push_back(8'h52);
    serve("ab2", 4'b0001, lat);
    bus.req = '0;

    // tx_done on the last WAIT cycle before abort
    apply_reset();
    set_req(3, 8'h77, 1'b1);
    step();
    chk("sim_start", 32'(bus.tx_start), 32'd1);
    repeat (15) step();
    chk("sim_pre", 32'({bus.timeout_err, dbg_state}), 32'({1'b0, 3'd2}));
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("sim_ack", 32'({bus.ack, bus.timeout_err}), 32'({4'b1000, 1'b0}));
    bus.req = '0;
    step();
    chk("sim_after", 32'({bus.timeout_err, bus.busy}), 32'd0);

    // reset in the middle of WAIT
    set_req(2, 8'h99, 1'b1);
    step();
    step();
    step();
    chk("mid_wait", 32'({dbg_state, bus.tx_data}), 32'({3'd2, 8'h99}));
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = '0;
    chk("mid_reset", all_out(), 32'd0);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("mid_done_ignored", all_out(), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
